// File: rtl/stack_pointer_unit.sv
// Stack-pointer unit for the 8085 datapath: word PUSH/POP as two byte-address cycles plus direct SP load.
// Define SP_BOUNDS_CHECK_EN to compile in the sticky overflow/underflow bounds checks.
module stack_pointer_unit #(
    parameter int            AW          = 16,
    parameter logic [AW-1:0] RESET_SP    = 16'h00FA,
    parameter logic [AW-1:0] STACK_LIMIT = 16'h00F0,
    parameter logic [AW-1:0] STACK_TOP   = 16'h00FA
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [AW-1:0] load_val,
    output logic          busy,
    output logic          done,
    output logic          addr_valid,
    output logic          byte_sel,
    output logic [AW-1:0] addr_bus,
    output logic [AW-1:0] sp_out,
    output logic          ovf,
    output logic          udf
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PUSH_H = 3'd1,
        PUSH_L = 3'd2,
        POP_L  = 3'd3,
        POP_H  = 3'd4
    } state_t;

    localparam logic [1:0]    OP_NONE = 2'b00;
    localparam logic [1:0]    OP_PUSH = 2'b01;
    localparam logic [1:0]    OP_POP  = 2'b10;
    localparam logic [1:0]    OP_LOAD = 2'b11;
    localparam logic [AW-1:0] SP_ONE  = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [AW-1:0] sp_q, sp_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          push_abort_s;
    logic          pop_abort_s;
    logic          cycle_active_s;

`ifdef SP_BOUNDS_CHECK_EN
    // One extra bit keeps LIMIT+2 and SP+2 from wrapping in the compares.
    localparam logic [AW:0] BOUND_TWO   = {{(AW-1){1'b0}}, 2'd2};
    localparam logic [AW:0] LIMIT_PLUS2 = {1'b0, STACK_LIMIT} + BOUND_TWO;
    assign push_abort_s = ({1'b0, sp_q} < LIMIT_PLUS2);
    assign pop_abort_s  = (({1'b0, sp_q} + BOUND_TWO) > {1'b0, STACK_TOP});
`else
    assign push_abort_s = 1'b0;
    assign pop_abort_s  = 1'b0;
`endif

    // State register, stack pointer, done pulse and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sp_q    <= RESET_SP;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Next-state and SP sequencing; en low freezes everything except the done pulse
    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (en) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_PUSH: begin
                                if (push_abort_s) begin
                                    ovf_d  = 1'b1;
                                    done_d = 1'b1;
                                end else begin
                                    sp_d    = sp_q - SP_ONE;
                                    state_d = PUSH_H;
                                end
                            end
                            OP_POP: begin
                                if (pop_abort_s) begin
                                    udf_d  = 1'b1;
                                    done_d = 1'b1;
                                end else begin
                                    state_d = POP_L;
                                end
                            end
                            OP_LOAD: begin
                                sp_d   = load_val;
                                ovf_d  = 1'b0;
                                udf_d  = 1'b0;
                                done_d = 1'b1;
                            end
                            OP_NONE: begin
                                state_d = IDLE;
                            end
                            default: begin
                                state_d = IDLE;
                            end
                        endcase
                    end else begin
                        state_d = IDLE;
                    end
                end
                PUSH_H: begin
                    sp_d    = sp_q - SP_ONE;
                    state_d = PUSH_L;
                end
                PUSH_L: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                POP_L: begin
                    sp_d    = sp_q + SP_ONE;
                    state_d = POP_H;
                end
                POP_H: begin
                    sp_d    = sp_q + SP_ONE;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    assign cycle_active_s = (state_q != IDLE);
    assign busy           = cycle_active_s;
    assign addr_valid     = cycle_active_s && en;
    assign byte_sel       = addr_valid && ((state_q == PUSH_H) || (state_q == POP_H));
    assign addr_bus       = addr_valid ? sp_q : {AW{1'bz}};
    assign sp_out         = sp_q;
    assign done           = done_q;
    assign ovf            = ovf_q;
    assign udf            = udf_q;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Directed self-checking bench for stack_pointer_unit; follows SP_BOUNDS_CHECK_EN when defined.
module tb_stack_pointer_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] load_val = 16'h0000;
    logic        busy, done, addr_valid, byte_sel, ovf, udf;
    logic [15:0] addr_bus, sp_out;

    int pass_cnt  = 0;
    int total_cnt = 0;

    stack_pointer_unit dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .start      (start),
        .op         (op),
        .load_val   (load_val),
        .busy       (busy),
        .done       (done),
        .addr_valid (addr_valid),
        .byte_sel   (byte_sel),
        .addr_bus   (addr_bus),
        .sp_out     (sp_out),
        .ovf        (ovf),
        .udf        (udf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A released bus floats; two-state simulation resolves the float to zero.
    function automatic logic released(input logic [15:0] bus);
        return (bus === 16'hzzzz) || (bus === 16'h0000);
    endfunction

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; start = 1'b0; op = 2'b00;
        step(); step();
        total_cnt++; if (sp_out !== 16'h00FA) $display("FAIL reset_sp got %h exp 00fa", sp_out); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
        total_cnt++; if (addr_valid !== 1'b0 || byte_sel !== 1'b0) $display("FAIL reset_addr_valid got %b/%b exp 0/0", addr_valid, byte_sel); else pass_cnt++;
        total_cnt++; if (!released(addr_bus)) $display("FAIL reset_bus got %h exp released", addr_bus); else pass_cnt++;
        total_cnt++; if (ovf !== 1'b0 || udf !== 1'b0) $display("FAIL reset_flags got %b/%b exp 0/0", ovf, udf); else pass_cnt++;
        reset = 1'b0;
        start = 1'b1; op = 2'b01;
        step();
        start = 1'b0; op = 2'b00;
        total_cnt++; if (busy !== 1'b1 || sp_out !== 16'h00F9) $display("FAIL midpush_enter got busy=%b sp=%h exp 1/00f9", busy, sp_out); else pass_cnt++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        total_cnt++; if (busy !== 1'b0 || sp_out !== 16'h00FA) $display("FAIL midpush_reset got busy=%b sp=%h exp 0/00fa", busy, sp_out); else pass_cnt++;
        total_cnt++; if (addr_valid !== 1'b0) $display("FAIL midpush_reset_valid got %b exp 0", addr_valid); else pass_cnt++;
    endtask

    task automatic test_push();
        start = 1'b1; op = 2'b01;
        step();
        start = 1'b0; op = 2'b00;
        total_cnt++; if (addr_valid !== 1'b1 || addr_bus !== 16'h00F9 || byte_sel !== 1'b1) $display("FAIL push_h got v=%b a=%h bs=%b exp 1/00f9/1", addr_valid, addr_bus, byte_sel); else pass_cnt++;
        step();
        total_cnt++; if (addr_valid !== 1'b1 || addr_bus !== 16'h00F8 || byte_sel !== 1'b0) $display("FAIL push_l got v=%b a=%h bs=%b exp 1/00f8/0", addr_valid, addr_bus, byte_sel); else pass_cnt++;
        step();
        total_cnt++; if (done !== 1'b1 || busy !== 1'b0 || sp_out !== 16'h00F8) $display("FAIL push_done got d=%b b=%b sp=%h exp 1/0/00f8", done, busy, sp_out); else pass_cnt++;
        step();
        total_cnt++; if (done !== 1'b0) $display("FAIL push_done_fall got %b exp 0", done); else pass_cnt++;
    endtask

    task automatic test_pop();
        start = 1'b1; op = 2'b10;
        step();
        start = 1'b0; op = 2'b00;
        total_cnt++; if (addr_valid !== 1'b1 || addr_bus !== 16'h00F8 || byte_sel !== 1'b0) $display("FAIL pop_l got v=%b a=%h bs=%b exp 1/00f8/0", addr_valid, addr_bus, byte_sel); else pass_cnt++;
        step();
        total_cnt++; if (addr_valid !== 1'b1 || addr_bus !== 16'h00F9 || byte_sel !== 1'b1) $display("FAIL pop_h got v=%b a=%h bs=%b exp 1/00f9/1", addr_valid, addr_bus, byte_sel); else pass_cnt++;
        step();
        total_cnt++; if (done !== 1'b1 || busy !== 1'b0 || sp_out !== 16'h00FA) $display("FAIL pop_done got d=%b b=%b sp=%h exp 1/0/00fa", done, busy, sp_out); else pass_cnt++;
        step();
        total_cnt++; if (done !== 1'b0) $display("FAIL pop_done_fall got %b exp 0", done); else pass_cnt++;
    endtask

    task automatic load_sp(input logic [15:0] val);
        start = 1'b1; op = 2'b11; load_val = val;
        step();
        start = 1'b0; op = 2'b00;
    endtask

    task automatic test_overflow();
        load_sp(16'h00F1);
        total_cnt++; if (done !== 1'b1 || sp_out !== 16'h00F1 || busy !== 1'b0) $display("FAIL load_f1 got d=%b sp=%h b=%b exp 1/00f1/0", done, sp_out, busy); else pass_cnt++;
        start = 1'b1; op = 2'b01;
        step();
        start = 1'b0; op = 2'b00;
`ifdef SP_BOUNDS_CHECK_EN
        total_cnt++; if (ovf !== 1'b1 || done !== 1'b1 || sp_out !== 16'h00F1) $display("FAIL ovf_abort got ovf=%b d=%b sp=%h exp 1/1/00f1", ovf, done, sp_out); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || addr_valid !== 1'b0) $display("FAIL ovf_no_cycle got b=%b v=%b exp 0/0", busy, addr_valid); else pass_cnt++;
        step();
        total_cnt++; if (ovf !== 1'b1 || done !== 1'b0) $display("FAIL ovf_sticky got ovf=%b d=%b exp 1/0", ovf, done); else pass_cnt++;
`else
        total_cnt++; if (addr_valid !== 1'b1 || addr_bus !== 16'h00F0) $display("FAIL nochk_push_h got v=%b a=%h exp 1/00f0", addr_valid, addr_bus); else pass_cnt++;
        step();
        total_cnt++; if (addr_bus !== 16'h00EF || byte_sel !== 1'b0) $display("FAIL nochk_push_l got a=%h bs=%b exp 00ef/0", addr_bus, byte_sel); else pass_cnt++;
        step();
        total_cnt++; if (sp_out !== 16'h00EF || done !== 1'b1 || ovf !== 1'b0) $display("FAIL nochk_push_done got sp=%h d=%b ovf=%b exp 00ef/1/0", sp_out, done, ovf); else pass_cnt++;
`endif
        load_sp(16'h00F4);
        total_cnt++; if (ovf !== 1'b0 || sp_out !== 16'h00F4) $display("FAIL load_clear_ovf got ovf=%b sp=%h exp 0/00f4", ovf, sp_out); else pass_cnt++;
    endtask

    task automatic test_underflow();
        load_sp(16'h00FA);
        start = 1'b1; op = 2'b10;
        step();
        start = 1'b0; op = 2'b00;
`ifdef SP_BOUNDS_CHECK_EN
        total_cnt++; if (udf !== 1'b1 || done !== 1'b1 || sp_out !== 16'h00FA || busy !== 1'b0) $display("FAIL udf_abort got udf=%b d=%b sp=%h b=%b exp 1/1/00fa/0", udf, done, sp_out, busy); else pass_cnt++;
`else
        total_cnt++; if (addr_bus !== 16'h00FA || byte_sel !== 1'b0) $display("FAIL nochk_pop_l got a=%h bs=%b exp 00fa/0", addr_bus, byte_sel); else pass_cnt++;
        step();
        total_cnt++; if (addr_bus !== 16'h00FB || byte_sel !== 1'b1) $display("FAIL nochk_pop_h got a=%h bs=%b exp 00fb/1", addr_bus, byte_sel); else pass_cnt++;
        step();
        total_cnt++; if (sp_out !== 16'h00FC || done !== 1'b1 || udf !== 1'b0) $display("FAIL nochk_pop_done got sp=%h d=%b udf=%b exp 00fc/1/0", sp_out, done, udf); else pass_cnt++;
`endif
        load_sp(16'h00FA);
        total_cnt++; if (udf !== 1'b0 || sp_out !== 16'h00FA) $display("FAIL load_clear_udf got udf=%b sp=%h exp 0/00fa", udf, sp_out); else pass_cnt++;
    endtask

    task automatic test_stall();
        start = 1'b1; op = 2'b01;
        step();
        start = 1'b0; op = 2'b00;
        en = 1'b0;
        #1;
        total_cnt++; if (addr_valid !== 1'b0 || !released(addr_bus)) $display("FAIL stall_release got v=%b a=%h exp 0/released", addr_valid, addr_bus); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++; if (sp_out !== 16'h00F9 || busy !== 1'b1 || addr_valid !== 1'b0) $display("FAIL stall_hold%0d got sp=%h b=%b v=%b exp 00f9/1/0", i, sp_out, busy, addr_valid); else pass_cnt++;
        end
        en = 1'b1;
        #1;
        total_cnt++; if (addr_valid !== 1'b1 || addr_bus !== 16'h00F9 || byte_sel !== 1'b1) $display("FAIL resume_h got v=%b a=%h bs=%b exp 1/00f9/1", addr_valid, addr_bus, byte_sel); else pass_cnt++;
        start = 1'b1; op = 2'b10;
        step();
        start = 1'b0; op = 2'b00;
        total_cnt++; if (addr_bus !== 16'h00F8 || byte_sel !== 1'b0) $display("FAIL resume_l got a=%h bs=%b exp 00f8/0", addr_bus, byte_sel); else pass_cnt++;
        step();
        total_cnt++; if (done !== 1'b1 || sp_out !== 16'h00F8) $display("FAIL resume_done got d=%b sp=%h exp 1/00f8", done, sp_out); else pass_cnt++;
        step();
        total_cnt++; if (busy !== 1'b0 || sp_out !== 16'h00F8) $display("FAIL start_ignored got b=%b sp=%h exp 0/00f8", busy, sp_out); else pass_cnt++;
        load_sp(16'h00FA);
        en = 1'b0;
        step();
        total_cnt++; if (done !== 1'b0 || sp_out !== 16'h00FA) $display("FAIL done_fall_stalled got d=%b sp=%h exp 0/00fa", done, sp_out); else pass_cnt++;
        en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_push();
        test_pop();
        test_overflow();
        test_underflow();
        test_stall();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
